mem_ctrl: RTL
=============

# mem_ctrl

Byte-serial memory controller that shares the single 8-bit RAM port between instruction fetch (IF) and the load/store stage (MEM). It sequences 1-, 2- or 4-byte little-endian transfers, gives MEM priority over IF, and aborts an in-flight fetch when the execute stage redirects the PC. It sits between the IF and MEM pipeline stages and the external RAM.

## Interface
- No parameters. All addresses and words are 32 bits.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_done or dropped by the requester
- if_addr  in  32  fetch byte address; always a 4-byte read
- if_clr  in  1  kill pending/in-flight fetch (PC redirect)
- if_done  out  1  one-cycle pulse; if_data valid that cycle
- if_data  out  32  fetched instruction word
- mem_req  in  1  load/store request; held until mem_done
- mem_wr  in  1  1 = store, 0 = load
- mem_len  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- mem_addr  in  32  start byte address
- mem_wdata  in  32  store data; byte i goes to mem_addr+i
- mem_done  out  1  one-cycle pulse; mem_rdata valid that cycle for loads
- mem_rdata  out  32  load data, zero-extended above N bytes (sign extension belongs to MEM)
- ram_a  out  32  RAM byte address
- ram_wr  out  1  RAM write enable
- ram_dout  out  8  RAM write data
- ram_din  in  8  RAM read data; reflects the ram_a driven in the previous cycle

## Operation
- States: IDLE, RD, WR, DONE. A 3-bit issue counter and a 3-bit receive counter. An owner flag (IF/MEM). N = 1/2/4 from the length field.
- In IDLE at an edge:
  - mem_req=1: grant MEM; latch addr, len, wdata and wr.
  - Otherwise if_req=1 and if_clr=0: grant IF with N=4.
  - Otherwise stay in IDLE.
  - MEM always wins a simultaneous request.
- Grant edge: ram_a=addr, issue count=1. State goes to RD or WR.
  - WR also drives ram_wr=1 and ram_dout=byte0.
- WR, at each edge:
  - If issue count = N: ram_wr=0, ram_a=0, set done, go to DONE.
  - Otherwise drive ram_a=addr+count and ram_dout=byte[count], then count+1.
- RD, at each edge:
  - If issue count < N: drive addr+count, then count+1. Once count reaches N, ram_a holds its last value.
  - From the second edge after grant, capture ram_din into byte[rcv], then rcv+1.
  - When byte N-1 is captured, set done and go to DONE.
- DONE lasts exactly one cycle. At the next edge done clears and state returns to IDLE. IDLE therefore lasts at least one cycle between transactions.
- Address arithmetic is 32-bit and wraps modulo 2^32; no alignment checks.
- Output ownership:
  - if_data and mem_rdata are registered and hold their last value outside done.
  - Only the owner's done pulses.
- Abort: if if_clr=1 at an edge while state=RD and owner=IF:
  - Return to IDLE. Clear ram_a, counters and captured bytes.
  - No if_done is produced.
  - Abort wins over a same-edge done.
- if_clr has no effect on MEM transactions or on DONE.
- If if_clr=1 at an IDLE edge, IF is not granted on that edge.
- Reset (any time, including mid-transaction):
  - State goes to IDLE.
  - All outputs are 0: ram_a, ram_wr, ram_dout, if_done, if_data, mem_done, mem_rdata.
  - The partial transaction is discarded; a partial write leaves already-written bytes in RAM.

## Timing
- E0 = grant edge, Ek = k-th edge after E0.
- Write of N bytes: byte i is on the RAM port in the cycle after Ei. Done is set at EN (word store: E4).
- Read of N bytes: address i is issued at Ei and captured at E(i+2). Done is set at E(N+1) (word read: E5; byte load: E2).
- A done pulse is high for exactly one cycle. Requesters sample it and drop req by the following edge.
- ram_wr is never high outside WR.

## Test plan
- IF word fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,00,00,00 -> if_done at E5, if_data=0x00000013; RAM addresses 0x100..0x103 issued at E0..E3.
- Byte store: mem_wr=1, mem_len=0, mem_addr=0x20, mem_wdata=0xAABBCCDD -> one cycle of ram_wr=1 with ram_a=0x20 and ram_dout=0xDD; mem_done at E1; RAM[0x21] unchanged.
- Half load zero-extend: RAM[0x40]=0x80, RAM[0x41]=0xFF, mem_len=1 -> mem_done at E3, mem_rdata=0x0000FF80.
- Simultaneous request: if_req and mem_req rise together -> MEM served first; IF granted on the first IDLE edge after mem_done; if_done follows 5 edges later.
- Fetch abort: if_clr=1 at E2 of an IF read -> state returns to IDLE, no if_done; a new if_req to 0x200 then returns the correct word.
- Reset mid-store: rst asserted after E1 of a word store -> all outputs 0 immediately; no mem_done; next request is served normally from IDLE.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one 8-bit RAM port between instruction fetch
// and load/store. MEM wins arbitration; a PC redirect can kill an IF read.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_clr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t          state_q, state_d;
  logic            own_mem_q, own_mem_d;
  logic [2:0]      n_q, n_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0][7:0] wdata_q, wdata_d;
  logic [2:0]      icnt_q, icnt_d;
  logic [2:0]      rcnt_q, rcnt_d;
  logic            cap_q, cap_d;
  logic [3:0][7:0] rbuf_q, rbuf_d;
  logic [31:0]     ram_a_q, ram_a_d;
  logic            ram_wr_q, ram_wr_d;
  logic [7:0]      ram_dout_q, ram_dout_d;
  logic            if_done_q, if_done_d;
  logic [31:0]     if_data_q, if_data_d;
  logic            mem_done_q, mem_done_d;
  logic [31:0]     mem_rdata_q, mem_rdata_d;
  logic [2:0]      mem_n;

  // Length code 3 is illegal and falls through to a full word.
  assign mem_n = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    state_d     = state_q;
    own_mem_d   = own_mem_q;
    n_d         = n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    icnt_d      = icnt_q;
    rcnt_d      = rcnt_q;
    cap_d       = cap_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_wr_d    = ram_wr_q;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req || (if_req && !if_clr)) begin
          own_mem_d = mem_req;
          addr_d    = mem_req ? mem_addr : if_addr;
          n_d       = mem_req ? mem_n : 3'd4;
          wdata_d   = mem_wdata;
          icnt_d    = 3'd1;
          rcnt_d    = 3'd0;
          cap_d     = 1'b0;
          rbuf_d    = '0;
          ram_a_d   = mem_req ? mem_addr : if_addr;
          if (mem_req && mem_wr) begin
            state_d    = WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        if (icnt_q == n_q) begin
          ram_wr_d   = 1'b0;
          ram_a_d    = '0;
          mem_done_d = 1'b1;
          state_d    = DONE;
        end else begin
          ram_a_d    = addr_q + {29'd0, icnt_q};
          ram_dout_d = wdata_q[icnt_q[1:0]];
          icnt_d     = icnt_q + 3'd1;
        end
      end
      RD: begin
        if (!own_mem_q && if_clr) begin
          state_d = IDLE;
          ram_a_d = '0;
          icnt_d  = '0;
          rcnt_d  = '0;
          cap_d   = 1'b0;
          rbuf_d  = '0;
        end else begin
          if (icnt_q < n_q) begin
            ram_a_d = addr_q + {29'd0, icnt_q};
            icnt_d  = icnt_q + 3'd1;
          end
          // RAM read data lags the address by one cycle, so capture starts
          // on the second RD edge.
          cap_d = 1'b1;
          if (cap_q) begin
            rbuf_d[rcnt_q[1:0]] = ram_din;
            rcnt_d              = rcnt_q + 3'd1;
            if (rcnt_q == n_q - 3'd1) begin
              state_d = DONE;
              if (own_mem_q) begin
                mem_done_d  = 1'b1;
                mem_rdata_d = rbuf_d;
              end else begin
                if_done_d = 1'b1;
                if_data_d = rbuf_d;
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      own_mem_q   <= 1'b0;
      n_q         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      icnt_q      <= '0;
      rcnt_q      <= '0;
      cap_q       <= 1'b0;
      rbuf_q      <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_mem_q   <= own_mem_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      icnt_q      <= icnt_d;
      rcnt_q      <= rcnt_d;
      cap_q       <= cap_d;
      rbuf_q      <= rbuf_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;

endmodule
